spi_multi_cs_dac_if: RTL and testbench

//  OPB-mapped SPI master for multi-device DAC/ADC boards. Generalises the single-CS DAC port:

---
 rtl/spi_if_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/spi_multi_cs_dac_if.sv | 254 +++++++++++++++++++++++++
 tb/tb_spi_multi_cs_dac_if.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_if_pkg.sv
// ============================================================================
//  Module   : spi_if_pkg
//  Brief    : Shared encodings for the multi-CS SPI DAC/ADC interface.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package spi_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [1:0] c_reg_cmd  = 2'd0;
    localparam logic [1:0] c_reg_ctrl = 2'd1;
    localparam logic [1:0] c_reg_stat = 2'd2;
    localparam logic [1:0] c_reg_rxd  = 2'd3;

    localparam int c_ctrl_cpol = 16;
    localparam int c_ctrl_cpha = 17;

    localparam int c_stat_busy   = 0;
    localparam int c_stat_rxv    = 1;
    localparam int c_stat_ovf    = 2;
    localparam int c_stat_cs_err = 3;

    localparam int c_cmd_rb     = 31;
    localparam int c_cmd_cs_lsb = 24;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock first-word-fall-through FIFO with occupancy count.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int c_depth = 2**AW;

    logic [DW-1:0] r_mem [c_depth];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full    = (r_count == (AW+1)'(c_depth));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_push    = i_wr_en & ~o_full;
    assign w_pop     = i_rd_en & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_multi_cs_dac_if.sv
// ============================================================================
//  Module   : spi_multi_cs_dac_if
//  Brief    : OPB-mapped SPI master with command FIFO, multiple chip selects,
//             runtime divider/CPOL/CPHA and read-back capture.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_multi_cs_dac_if
    import spi_if_pkg::*;
#(
    parameter int FRAME_W     = 24,
    parameter int NUM_CS      = 4,
    parameter int FIFO_AW     = 4,
    parameter int DIV_DEFAULT = 4
) (
    input  logic              OPB_CLK,
    input  logic              OPB_RST,
    input  logic [31:0]       OPB_ADDR,
    input  logic [31:0]       OPB_DI,
    input  logic              OPB_WE,
    input  logic              OPB_RE,
    output logic [31:0]       OPB_DO,
    output logic              SPI_SCLK,
    output logic              SPI_MOSI,
    output logic [NUM_CS-1:0] SPI_CS_N,
    input  logic              SPI_MISO
);

    localparam int              c_fifo_dw   = FRAME_W + 5;
    localparam int              c_ecw       = $clog2(2*FRAME_W);
    localparam logic [c_ecw-1:0] c_last_edge = c_ecw'(2*FRAME_W - 1);
    localparam logic [4:0]      c_num_cs    = 5'(NUM_CS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_div;
    logic                 r_cpol;
    logic                 r_cpha;
    logic [15:0]          r_hp_cnt;
    logic [15:0]          r_sh_div;
    logic                 r_sh_cpha;
    logic                 r_sclk;
    logic                 r_rb;
    logic [3:0]           r_cs;
    logic [c_ecw-1:0]     r_edge_cnt;
    logic [FRAME_W-1:0]   r_tx;
    logic [FRAME_W-1:0]   r_rx;
    logic [FRAME_W-1:0]   r_rx_frame;
    logic                 r_rx_valid;
    logic                 r_ovf;
    logic                 r_cs_err;

    logic [1:0]           w_sel;
    logic                 w_wr_cmd;
    logic                 w_wr_ctrl;
    logic                 w_wr_stat;
    logic                 w_rd_rxd;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_cs_ok;
    logic                 w_cs_bad;
    logic                 w_active;
    logic                 w_busy;
    logic                 w_hp_done;
    logic                 w_edge;
    logic                 w_lead;
    logic                 w_sample;
    logic                 w_shift;
    logic                 w_capture;
    logic [NUM_CS-1:0]    w_cs_dec;
    logic [c_fifo_dw-1:0] w_fifo_rd;
    logic [FIFO_AW:0]     w_fifo_cnt;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_f_rb;
    logic [3:0]           w_f_cs;
    logic [FRAME_W-1:0]   w_f_frame;
    logic                 w_unused;

    assign w_sel     = OPB_ADDR[3:2];
    assign w_wr_cmd  = OPB_WE && (w_sel == c_reg_cmd);
    assign w_wr_ctrl = OPB_WE && (w_sel == c_reg_ctrl);
    assign w_wr_stat = OPB_WE && (w_sel == c_reg_stat);
    assign w_rd_rxd  = OPB_RE && (w_sel == c_reg_rxd);
    assign w_push    = w_wr_cmd & ~w_fifo_full;
    assign w_unused  = ^{OPB_ADDR[31:4], OPB_ADDR[1:0], OPB_DI};

    sync_fifo #(
        .DW (c_fifo_dw),
        .AW (FIFO_AW)
    ) u_cmd_fifo (
        .clk       (OPB_CLK),
        .rst       (OPB_RST),
        .i_wr_en   (w_push),
        .i_wr_data ({OPB_DI[c_cmd_rb], OPB_DI[c_cmd_cs_lsb +: 4], OPB_DI[FRAME_W-1:0]}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_rd),
        .o_count   (w_fifo_cnt),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign w_f_rb    = w_fifo_rd[FRAME_W+4];
    assign w_f_cs    = w_fifo_rd[FRAME_W+3:FRAME_W];
    assign w_f_frame = w_fifo_rd[FRAME_W-1:0];
    assign w_cs_ok   = ({1'b0, w_f_cs} < c_num_cs);
    assign w_cs_bad  = w_pop & ~w_cs_ok;

    assign w_active  = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
    assign w_busy    = (r_state != ST_IDLE) || !w_fifo_empty;
    assign w_hp_done = (r_state != ST_IDLE) && (r_hp_cnt == r_sh_div);

    // Edge k of the frame opens SHIFT half-period k; even k are leading edges.
    // The SETUP->SHIFT transition is edge 0, so r_edge_cnt odd means the next edge is leading.
    assign w_edge    = w_hp_done && ((r_state == ST_SETUP) ||
                                     ((r_state == ST_SHIFT) && (r_edge_cnt != c_last_edge)));
    assign w_lead    = (r_state == ST_SETUP) || r_edge_cnt[0];
    assign w_sample  = w_edge && (w_lead ^ r_sh_cpha);
    // The MSB is already on MOSI from SETUP, so the first leading edge never shifts.
    assign w_shift   = w_edge && !w_sample && (r_state != ST_SETUP);
    assign w_capture = (r_state == ST_HOLD) && w_hp_done && r_rb;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (w_cs_ok) begin
                        w_state_nxt = ST_SETUP;
                    end
                end
            end
            ST_SETUP: if (w_hp_done) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_hp_done && (r_edge_cnt == c_last_edge)) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (w_hp_done) w_state_nxt = ST_GAP;
            ST_GAP:   if (w_hp_done) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            r_hp_cnt   <= '0;
            r_edge_cnt <= '0;
            r_sh_div   <= 16'd1;
            r_sh_cpha  <= 1'b0;
            r_sclk     <= 1'b0;
            r_rb       <= 1'b0;
            r_cs       <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
        end else begin
            if ((r_state == ST_IDLE) || w_hp_done) begin
                r_hp_cnt <= '0;
            end else begin
                r_hp_cnt <= r_hp_cnt + 1'b1;
            end

            if (r_state != ST_SHIFT) begin
                r_edge_cnt <= '0;
            end else if (w_hp_done) begin
                r_edge_cnt <= r_edge_cnt + 1'b1;
            end

            if (w_pop && w_cs_ok) begin
                r_tx      <= w_f_frame;
                r_cs      <= w_f_cs;
                r_rb      <= w_f_rb;
                r_sh_cpha <= r_cpha;
                r_sclk    <= r_cpol;
                r_sh_div  <= (r_div == '0) ? 16'd1 : r_div;
            end else begin
                if (w_edge) begin
                    r_sclk <= ~r_sclk;
                end
                if (w_shift) begin
                    r_tx <= {r_tx[FRAME_W-2:0], 1'b0};
                end
                if (w_sample) begin
                    r_rx <= {r_rx[FRAME_W-2:0], SPI_MISO};
                end
            end
        end
    end

    // Set events take priority over the clears in this block.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            r_div      <= 16'(DIV_DEFAULT);
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_rx_frame <= '0;
            r_rx_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_cs_err   <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_div  <= OPB_DI[15:0];
                r_cpol <= OPB_DI[c_ctrl_cpol];
                r_cpha <= OPB_DI[c_ctrl_cpha];
            end

            if (w_capture) begin
                r_rx_frame <= r_rx;
                r_rx_valid <= 1'b1;
            end else if (w_rd_rxd) begin
                r_rx_valid <= 1'b0;
            end

            if (w_wr_cmd && w_fifo_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat && OPB_DI[c_stat_ovf]) begin
                r_ovf <= 1'b0;
            end

            if (w_cs_bad) begin
                r_cs_err <= 1'b1;
            end else if (w_wr_stat && OPB_DI[c_stat_cs_err]) begin
                r_cs_err <= 1'b0;
            end
        end
    end

    assign w_cs_dec = NUM_CS'(1) << r_cs;
    assign SPI_CS_N = w_active ? ~w_cs_dec : '1;
    assign SPI_MOSI = w_active ? r_tx[FRAME_W-1] : 1'b0;
    // While idle SCLK follows the live CPOL so the bus parks at the programmed level.
    assign SPI_SCLK = (r_state == ST_IDLE) ? r_cpol : r_sclk;

    always_comb begin
        OPB_DO = '0;
        case (w_sel)
            c_reg_ctrl: OPB_DO = {14'd0, r_cpha, r_cpol, r_div};
            c_reg_stat: OPB_DO = {16'd0, 8'(w_fifo_cnt), 4'd0, r_cs_err, r_ovf, r_rx_valid, w_busy};
            c_reg_rxd:  OPB_DO = 32'(r_rx_frame);
            default:    OPB_DO = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_multi_cs_dac_if.sv
// ============================================================================
//  Module   : tb_spi_multi_cs_dac_if
//  Brief    : Scoreboard bench for spi_multi_cs_dac_if with an SPI slave model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_multi_cs_dac_if;

    localparam int FRAME_W = 24;
    localparam int NUM_CS  = 4;

    logic              OPB_CLK = 1'b0;
    logic              OPB_RST = 1'b1;
    logic [31:0]       OPB_ADDR = '0;
    logic [31:0]       OPB_DI = '0;
    logic              OPB_WE = 1'b0;
    logic              OPB_RE = 1'b0;
    logic [31:0]       OPB_DO;
    logic              SPI_SCLK;
    logic              SPI_MOSI;
    logic [NUM_CS-1:0] SPI_CS_N;
    logic              SPI_MISO = 1'b0;

    spi_multi_cs_dac_if #(
        .FRAME_W     (FRAME_W),
        .NUM_CS      (NUM_CS),
        .FIFO_AW     (4),
        .DIV_DEFAULT (4)
    ) u_dut (
        .OPB_CLK  (OPB_CLK),
        .OPB_RST  (OPB_RST),
        .OPB_ADDR (OPB_ADDR),
        .OPB_DI   (OPB_DI),
        .OPB_WE   (OPB_WE),
        .OPB_RE   (OPB_RE),
        .OPB_DO   (OPB_DO),
        .SPI_SCLK (SPI_SCLK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_CS_N (SPI_CS_N),
        .SPI_MISO (SPI_MISO)
    );

    always #5 OPB_CLK = ~OPB_CLK;

    typedef struct {
        logic [NUM_CS-1:0]  cs_n;
        logic [FRAME_W-1:0] frame;
        int                 period;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic               tb_cpha  = 1'b0;
    logic               tb_abort = 1'b0;
    logic [FRAME_W-1:0] miso_pat = '0;
    int                 sclk_toggles = 0;
    int                 m_bits = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int cs, input logic [FRAME_W-1:0] frame, input int div);
        exp_t e;
        e.cs_n   = ~(NUM_CS'(1) << cs);
        e.frame  = frame;
        e.period = 2 * (((div == 0) ? 1 : div) + 1);
        exp_q.push_back(e);
    endtask

    task automatic opb_write(input logic [1:0] reg_idx, input logic [31:0] data);
        OPB_ADDR = {28'd0, reg_idx, 2'b00};
        OPB_DI   = data;
        OPB_WE   = 1'b1;
        @(negedge OPB_CLK);
        OPB_WE   = 1'b0;
    endtask

    task automatic opb_read(input logic [1:0] reg_idx, output logic [31:0] data);
        OPB_ADDR = {28'd0, reg_idx, 2'b00};
        OPB_RE   = 1'b1;
        #1 data  = OPB_DO;
        @(negedge OPB_CLK);
        OPB_RE   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] s;
        s = 32'd1;
        for (int i = 0; i < budget; i++) begin
            opb_read(2'd2, s);
            if (!s[0]) break;
        end
        if (s[0]) check("idle_timeout", s[0], 0);
    endtask

    // SPI slave: collects MOSI on the sampling edge, drives MISO on the other edge.
    initial begin
        logic               prev_sclk;
        logic               m_active;
        logic               m_cpol;
        logic               lead;
        logic [NUM_CS-1:0]  m_cs_n;
        logic [FRAME_W-1:0] m_frame;
        int                 m_idx;
        int                 m_first;
        int                 m_period;
        int                 cyc;
        exp_t               e;
        prev_sclk = 1'b0;
        m_active  = 1'b0;
        m_cpol    = 1'b0;
        m_cs_n    = '1;
        m_frame   = '0;
        m_idx     = 0;
        m_first   = -1;
        m_period  = 0;
        cyc       = 0;
        forever begin
            @(negedge OPB_CLK);
            cyc++;
            if (SPI_SCLK !== prev_sclk) sclk_toggles++;
            if (!m_active && (SPI_CS_N != '1)) begin
                m_active = 1'b1;
                m_cs_n   = SPI_CS_N;
                m_cpol   = SPI_SCLK;
                m_frame  = '0;
                m_bits   = 0;
                m_first  = -1;
                m_period = 0;
                m_idx    = FRAME_W - 1;
                if (!tb_cpha) SPI_MISO = miso_pat[m_idx];
            end else if (m_active && (SPI_CS_N == '1)) begin
                m_active = 1'b0;
                if (!tb_abort) begin
                    if (exp_q.size() == 0) begin
                        check("frame_count", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("cs_n", m_cs_n, e.cs_n);
                        check("mosi_frame", m_frame, e.frame);
                        check("bit_count", m_bits, FRAME_W);
                        check("sclk_period", m_period, e.period);
                    end
                end
            end else if (m_active && (SPI_SCLK !== prev_sclk)) begin
                lead = (SPI_SCLK != m_cpol);
                if (lead) begin
                    if (m_first < 0) m_first = cyc;
                    else if (m_period == 0) m_period = cyc - m_first;
                end
                if (lead ^ tb_cpha) begin
                    m_frame = {m_frame[FRAME_W-2:0], SPI_MOSI};
                    m_bits++;
                end else if (tb_cpha) begin
                    if (m_idx >= 0) SPI_MISO = miso_pat[m_idx];
                    m_idx--;
                end else begin
                    m_idx--;
                    if (m_idx >= 0) SPI_MISO = miso_pat[m_idx];
                end
            end
            prev_sclk = SPI_SCLK;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [FRAME_W-1:0] fr;
        int t0;

        repeat (3) @(negedge OPB_CLK);
        OPB_RST = 1'b0;
        @(negedge OPB_CLK);

        check("rst_cs_n", SPI_CS_N, 4'hF);
        check("rst_sclk", SPI_SCLK, 0);
        check("rst_mosi", SPI_MOSI, 0);
        opb_read(2'd2, d); check("rst_stat", d, 32'h0);
        opb_read(2'd1, d); check("rst_ctrl", d, 32'h4);

        // Mode 0 frame to cs 3, with pop/CS latency
        tb_cpha = 1'b0;
        push_exp(3, 24'h123456, 4);
        opb_write(2'd0, 32'h0312_3456);
        check("lat_n1_cs_n", SPI_CS_N, 4'hF);
        @(negedge OPB_CLK);
        check("lat_n2_cs_n", SPI_CS_N, 4'b0111);
        wait_idle(2000);

        // Mode 3 read-back
        opb_write(2'd1, 32'h0003_0004);
        tb_cpha = 1'b1;
        @(negedge OPB_CLK);
        check("cpol_idle", SPI_SCLK, 1);
        miso_pat = 24'hA5C3F0;
        push_exp(0, 24'h3C96E1, 4);
        opb_write(2'd0, 32'h8000_0000 | 32'h003C96E1);
        wait_idle(2000);
        check("cpol_idle_after", SPI_SCLK, 1);
        opb_read(2'd2, d); check("stat_rxv", d, 32'h2);
        opb_read(2'd3, d); check("rxd", d, 32'h00A5_C3F0);
        opb_read(2'd2, d); check("stat_rxv_clr", d, 32'h0);

        // FIFO overflow behind a slow frame
        opb_write(2'd1, 32'd20);
        tb_cpha = 1'b0;
        push_exp(0, 24'hF0F0F0, 20);
        opb_write(2'd0, 32'h0000_0000 | 32'h00F0F0F0);
        for (int i = 0; i < 17; i++) begin
            fr = 24'h100000 + 24'(i * 24'h1111);
            if (i < 16) push_exp(i % 4, fr, 1);
            opb_write(2'd0, {4'd0, 4'(i % 4), 24'd0} | 32'(fr));
        end
        opb_read(2'd2, d); check("stat_full_ovf", d, 32'h1005);
        opb_write(2'd1, 32'd1);
        wait_idle(6000);
        opb_read(2'd2, d); check("stat_ovf_idle", d, 32'h4);
        opb_write(2'd2, 32'h4);
        opb_read(2'd2, d); check("stat_ovf_w1c", d, 32'h0);

        // Illegal chip select
        t0 = sclk_toggles;
        opb_write(2'd0, 32'h0500_00AA);
        repeat (20) @(negedge OPB_CLK);
        check("cs_err_no_sclk", sclk_toggles - t0, 0);
        check("cs_err_no_cs", SPI_CS_N, 4'hF);
        opb_read(2'd2, d); check("stat_cs_err", d, 32'h8);
        push_exp(1, 24'h00C0DE, 1);
        opb_write(2'd0, 32'h0100_C0DE);
        wait_idle(2000);
        opb_write(2'd2, 32'h8);
        opb_read(2'd2, d); check("stat_cs_err_w1c", d, 32'h0);

        // Divider change mid-frame
        opb_write(2'd1, 32'd4);
        push_exp(2, 24'hABCDEF, 4);
        push_exp(3, 24'h654321, 1);
        opb_write(2'd0, 32'h02AB_CDEF);
        opb_write(2'd0, 32'h0365_4321);
        repeat (100) @(negedge OPB_CLK);
        opb_write(2'd1, 32'd1);
        wait_idle(2000);

        // Reset in the middle of a frame
        opb_write(2'd1, 32'd4);
        tb_abort = 1'b1;
        opb_write(2'd0, 32'h025A_5A5A);
        for (int i = 0; i < 2000; i++) begin
            @(negedge OPB_CLK);
            #1;
            if (m_bits >= 10) break;
        end
        if (m_bits < 10) check("bit_wait", m_bits, 10);
        OPB_RST = 1'b1;
        #1;
        check("rst_mid_cs_n", SPI_CS_N, 4'hF);
        check("rst_mid_sclk", SPI_SCLK, 0);
        check("rst_mid_mosi", SPI_MOSI, 0);
        repeat (3) @(negedge OPB_CLK);
        OPB_RST = 1'b0;
        @(negedge OPB_CLK);
        tb_abort = 1'b0;
        opb_read(2'd2, d); check("rst_mid_stat", d, 32'h0);
        opb_read(2'd1, d); check("rst_mid_ctrl", d, 32'h4);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
